// File: rtl/sar_conv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sar_conv_ctrl_pkg
//   Shared definitions for the generic SAR conversion controller.
//   - sar_state_t        : controller state encoding (IDLE / SAMPLE / CONVERT)
//   - SAR_NBITS_DEFAULT  : default conversion resolution
//   - SAR_SAMPLE_DEFAULT : default number of track cycles per conversion
// -----------------------------------------------------------------------------
package sar_conv_ctrl_pkg;

    localparam int SAR_NBITS_DEFAULT  = 8;
    localparam int SAR_SAMPLE_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_conv_ctrl.sv
// -----------------------------------------------------------------------------
// sar_conv_ctrl
//   Successive-approximation conversion controller. A one-cycle start pulse
//   opens a tracking window of SAMPLE_CYCLES cycles, then NBITS bit trials are
//   run MSB first against the comparator. The finished code is published on
//   result together with a one-cycle done pulse.
//
// Ports
//   clk      in   1      conversion clock, rising edge
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      1-cycle conversion request
//   cmp      in   1      comparator, 1 = vin >= dac (for the current dac)
//   sample   out  1      track/hold control, 1 = tracking
//   dac      out  NBITS  DAC trial code
//   result   out  NBITS  last completed conversion code
//   done     out  1      1-cycle pulse, result updated in the same cycle
//   busy     out  1      conversion in progress (SAMPLE or CONVERT)
//   overrun  out  1      1-cycle pulse, a start was dropped while busy
// -----------------------------------------------------------------------------
module sar_conv_ctrl
    import sar_conv_ctrl_pkg::*;
#(
    parameter int NBITS         = SAR_NBITS_DEFAULT,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic             sample,
    output logic [NBITS-1:0] dac,
    output logic [NBITS-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             overrun
);

    localparam int IDX_W = $clog2(NBITS);
    localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [NBITS-1:0] DAC_MSB  = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_t       state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [IDX_W-1:0] idx_reg,     idx_next;
    logic [NBITS-1:0] dac_reg,     dac_next;
    logic [NBITS-1:0] result_reg,  result_next;
    logic             sample_reg,  sample_next;
    logic             done_reg,    done_next;
    logic             busy_reg,    busy_next;
    logic             overrun_reg, overrun_next;

    // Code after resolving the bit under trial: keep/clear it from cmp and,
    // unless this was the LSB, raise the next lower bit as the new trial.
    logic [NBITS-1:0] trial_code;

    always_comb begin
        trial_code          = dac_reg;
        trial_code[idx_reg] = cmp;
        if (idx_reg != '0) begin
            trial_code[idx_reg - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            dac_reg     <= '0;
            result_reg  <= '0;
            sample_reg  <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            dac_reg     <= dac_next;
            result_reg  <= result_next;
            sample_reg  <= sample_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        dac_next     = dac_reg;
        result_next  = result_reg;
        sample_next  = sample_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        overrun_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The done cycle is already IDLE, so a start there is taken
                // without a gap cycle.
                if (start) begin
                    state_next  = ST_SAMPLE;
                    cnt_next    = '0;
                    sample_next = 1'b1;
                    busy_next   = 1'b1;
                    dac_next    = '0;
                end
            end

            ST_SAMPLE: begin
                overrun_next = start;
                if (cnt_reg == CNT_LAST) begin
                    state_next  = ST_CONVERT;
                    sample_next = 1'b0;
                    dac_next    = DAC_MSB;
                    idx_next    = IDX_MSB;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_CONVERT: begin
                overrun_next = start;
                if (idx_reg == '0) begin
                    state_next  = ST_IDLE;
                    result_next = trial_code;
                    done_next   = 1'b1;
                    dac_next    = '0;
                    busy_next   = 1'b0;
                end else begin
                    dac_next = trial_code;
                    idx_next = idx_reg - 1'b1;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                sample_next = 1'b0;
                busy_next   = 1'b0;
                dac_next    = '0;
            end
        endcase
    end

    assign sample  = sample_reg;
    assign dac     = dac_reg;
    assign result  = result_reg;
    assign done    = done_reg;
    assign busy    = busy_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_conv_ctrl
//   Self-checking bench for sar_conv_ctrl (NBITS=8, SAMPLE_CYCLES=4) with an
//   ideal comparator cmp = (vin >= dac).
// -----------------------------------------------------------------------------
module tb_sar_conv_ctrl;

    localparam int NBITS = 8;
    localparam int SC    = 4;
    localparam int LAT   = SC + NBITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cmp;
    logic [NBITS-1:0] vin;
    logic             sample;
    logic [NBITS-1:0] dac;
    logic [NBITS-1:0] result;
    logic             done;
    logic             busy;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] vin;
        logic [7:0] exp_result;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] dac_seq [8];
    logic [7:0] prev_result;

    sar_conv_ctrl #(
        .NBITS         (NBITS),
        .SAMPLE_CYCLES (SC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cmp     (cmp),
        .sample  (sample),
        .dac     (dac),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    assign cmp = (vin >= dac);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full conversion with per-cycle checks of every output.
    task automatic convert(input logic [7:0] v, input logic [7:0] exp, input logic [7:0] prev);
        vin   = v;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n <= LAT; n++) begin
            if (n > 0) step();
            check("conv_sample",  sample,  32'(n < SC));
            check("conv_busy",    busy,    32'(n < LAT));
            check("conv_done",    done,    32'(n == LAT));
            check("conv_overrun", overrun, 32'd0);
            check("conv_result",  result,  (n == LAT) ? 32'(exp) : 32'(prev));
        end
        $display("conversion vin=0x%02h result=0x%02h done_at=t0+%0d", v, result, LAT);
    endtask

    initial begin
        vecs[0] = '{vin: 8'hA5, exp_result: 8'hA5};
        vecs[1] = '{vin: 8'h00, exp_result: 8'h00};
        vecs[2] = '{vin: 8'hFF, exp_result: 8'hFF};
        vecs[3] = '{vin: 8'h3C, exp_result: 8'h3C};
        vecs[4] = '{vin: 8'h01, exp_result: 8'h01};
        vecs[5] = '{vin: 8'h80, exp_result: 8'h80};
        dac_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        rst   = 1'b1;
        start = 1'b0;
        vin   = 8'h00;
        step();
        step();
        check("rst_sample",  sample,  32'd0);
        check("rst_dac",     dac,     32'd0);
        check("rst_result",  result,  32'd0);
        check("rst_done",    done,    32'd0);
        check("rst_busy",    busy,    32'd0);
        check("rst_overrun", overrun, 32'd0);
        rst = 1'b0;
        step();
        $display("reset released");

        // DAC trial sequence for vin=0xA5
        vin   = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= LAT; n++) begin
            step();
            if (n >= SC && n < LAT)
                check("seq_dac", dac, 32'(dac_seq[n-SC]));
            else
                check("seq_dac_zero", dac, 32'd0);
        end
        check("seq_done",   done,   32'd1);
        check("seq_result", result, 32'hA5);
        $display("dac sequence vin=0xA5 result=0x%02h", result);
        step();

        // Table-driven conversions
        prev_result = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            step();
            convert(vecs[i].vin, vecs[i].exp_result, prev_result);
            prev_result = vecs[i].exp_result;
        end
        step();

        // start 5 cycles into conversion: overrun only
        vin   = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= LAT + 10; n++) begin
            step();
            start = (n == 4);
            check("ovr_overrun", overrun, 32'(n == 5));
            check("ovr_done",    done,    32'(n == LAT));
            if (n == LAT) check("ovr_result", result, 32'hA5);
        end
        check("ovr_idle", busy, 32'd0);
        $display("overrun mid-conversion result=0x%02h", result);

        // start in the done cycle: back-to-back
        vin   = 8'hC3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= LAT; n++) step();
        check("b2b_done1",   done,   32'd1);
        check("b2b_result1", result, 32'hC3);
        vin   = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_busy",   busy,   32'd1);
        check("b2b_sample", sample, 32'd1);
        for (int m = 1; m <= LAT; m++) begin
            step();
            check("b2b_done2", done, 32'(m == LAT));
        end
        check("b2b_result2", result, 32'h5A);
        $display("back-to-back results 0xC3 then 0x%02h", result);
        step();

        // Reset during CONVERT at bit 3
        vin   = 8'h77;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 8; n++) step();
        check("abort_dac_bit3", dac, 32'h78);
        rst = 1'b1;
        #1;
        check("abort_sample",  sample,  32'd0);
        check("abort_dac",     dac,     32'd0);
        check("abort_result",  result,  32'd0);
        check("abort_busy",    busy,    32'd0);
        check("abort_done",    done,    32'd0);
        check("abort_overrun", overrun, 32'd0);
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            check("abort_nodone", done, 32'd0);
            check("abort_idle",   busy, 32'd0);
        end
        $display("reset mid-conversion aborted");
        convert(8'h3C, 8'h3C, 8'h00);
        step();

        // start held high for 3 cycles
        vin   = 8'h42;
        start = 1'b1;
        step();
        check("hold_ovr0", overrun, 32'd0);
        step();
        check("hold_ovr1", overrun, 32'd1);
        step();
        check("hold_ovr2", overrun, 32'd1);
        start = 1'b0;
        for (int n = 3; n <= LAT + 6; n++) begin
            step();
            check("hold_ovr_low", overrun, 32'd0);
            check("hold_done",    done,    32'(n == LAT));
            if (n == LAT) check("hold_result", result, 32'h42);
        end
        $display("held start result=0x%02h", result);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
